// File: rtl/decode_stage_pkg.sv
// Shared encoding for the decode stage: icode values, the "no register" index,
// the D/E register layout and the needReg/needCon tables shared with fetch.
package decode_stage_pkg;

   localparam logic [3:0] REG_NONE = 4'hF;

   typedef enum logic [3:0] {
      IC_NOP   = 4'd0,
      IC_RRMOV = 4'd1,
      IC_MEM   = 4'd2,
      IC_OP    = 4'd3,
      IC_JMP   = 4'd4,
      IC_CALL  = 4'd5
   } icode_e;

   typedef struct packed {
      logic       valid;
      logic [3:0] icode;
      logic [3:0] ifun;
      logic [3:0] srcA;
      logic [3:0] srcB;
      logic [3:0] dstE;
      logic [7:0] valC;
      logic [7:0] valP;
   } deReg_t;

   function automatic logic lookupNeedReg(input logic [3:0] icode, input logic [3:0] ifun);
      case (icode)
         IC_RRMOV:                return (ifun <= 4'd2);
         IC_MEM, IC_OP, IC_CALL:  return 1'b1;
         default:                 return 1'b0;
      endcase
   endfunction

   function automatic logic lookupNeedCon(input logic [3:0] icode, input logic [3:0] ifun);
      case (icode)
         IC_RRMOV:                return (ifun == 4'd1) || (ifun == 4'd2);
         IC_MEM, IC_JMP, IC_CALL: return 1'b1;
         default:                 return 1'b0;
      endcase
   endfunction

   function automatic logic lookupIllegal(input logic [3:0] icode, input logic [3:0] ifun);
      case (icode)
         IC_RRMOV:                              return (ifun > 4'd2);
         IC_NOP, IC_MEM, IC_OP, IC_JMP, IC_CALL: return 1'b0;
         default:                               return 1'b1;
      endcase
   endfunction

   // A bubble keeps valP so the PC trail stays visible in the D/E register.
   function automatic deReg_t makeBubble(input logic [7:0] valP);
      deReg_t b;
      b.valid = 1'b0;
      b.icode = 4'd0;
      b.ifun  = 4'd0;
      b.srcA  = REG_NONE;
      b.srcB  = REG_NONE;
      b.dstE  = REG_NONE;
      b.valC  = 8'h00;
      b.valP  = valP;
      return b;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode bus: instruction, next PC, qualifiers, and the back-pressure
// signal decode returns to fetch.
interface decode_stage_if;
   logic [23:0] instr_f;
   logic [7:0]  increPC_f;
   logic        valid_f;
   logic        error_f;
   logic        stall_f;

   modport master (output instr_f, increPC_f, valid_f, error_f, input stall_f);
   modport slave  (input instr_f, increPC_f, valid_f, error_f, output stall_f);
endinterface

// File: rtl/decode_stage_instr_field_decode.sv
// Purely combinational split of a 24-bit instruction into opcode, register
// selectors and constant, plus its register/constant/legality classification.
module instr_field_decode
   import decode_stage_pkg::*;
(
   input  logic [23:0] instr_f,
   output logic [3:0]  icode,
   output logic [3:0]  ifun,
   output logic [3:0]  srcA,
   output logic [3:0]  srcB,
   output logic [3:0]  dstE,
   output logic [7:0]  valC,
   output logic        needReg,
   output logic        needCon,
   output logic        illegal
);
   logic [3:0] rA;
   logic [3:0] rB;

   assign icode = instr_f[23:20];
   assign ifun  = instr_f[19:16];
   assign rA    = instr_f[15:12];
   assign rB    = instr_f[11:8];

   assign needReg = lookupNeedReg(icode, ifun);
   assign needCon = lookupNeedCon(icode, ifun);
   assign illegal = lookupIllegal(icode, ifun);

   assign srcA = needReg ? rA : REG_NONE;
   assign srcB = (icode == IC_MEM || icode == IC_OP) ? rB : REG_NONE;
   assign dstE = (icode == IC_RRMOV || icode == IC_OP) ? rB : REG_NONE;

   // The constant sits after the register byte when there is one, else right after the opcode byte.
   assign valC = !needCon ? 8'h00 : (needReg ? instr_f[7:0] : instr_f[15:8]);
endmodule

// File: rtl/decode_stage.sv
// Decode stage: field decode, load-use hazard detection, D/E pipeline register
// with flush/stall/bubble priority, sticky error and saturating bubble counter.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   decode_stage_if.slave    fetchBus,
   input  logic             stall_d,
   input  logic             flush_d,
   input  logic [3:0]       dstE_e,
   input  logic             isLoad_e,
   output logic [3:0]       icode_d,
   output logic [3:0]       ifun_d,
   output logic [3:0]       srcA_d,
   output logic [3:0]       srcB_d,
   output logic [3:0]       dstE_d,
   output logic [7:0]       valC_d,
   output logic [7:0]       valP_d,
   output logic             valid_d,
   output logic             error_d,
   output logic [CNT_W-1:0] bubble_cnt
);
   logic [3:0] icode, ifun, srcA, srcB, dstE;
   logic [7:0] valC;
   logic       needReg, needCon, illegal;
   logic       unusedClass;
   logic       hazard;

   deReg_t           deReg, deNext;
   logic             errReg, errNext;
   logic [CNT_W-1:0] cntReg, cntNext;

   instr_field_decode u_fields (
      .instr_f (fetchBus.instr_f),
      .icode   (icode),
      .ifun    (ifun),
      .srcA    (srcA),
      .srcB    (srcB),
      .dstE    (dstE),
      .valC    (valC),
      .needReg (needReg),
      .needCon (needCon),
      .illegal (illegal)
   );

   // The register/constant classification is already folded into srcA and valC here.
   assign unusedClass = needReg ^ needCon;

   assign hazard = fetchBus.valid_f && isLoad_e && (dstE_e != REG_NONE)
                   && ((dstE_e == srcA) || (dstE_e == srcB));
   assign fetchBus.stall_f = hazard && !flush_d;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      deNext  = deReg;
      cntNext = cntReg;
      errNext = errReg | fetchBus.error_f;
      if (flush_d) begin
         deNext = makeBubble(deReg.valP);
      end else if (stall_d) begin
         deNext = deReg;
      end else if (hazard) begin
         deNext = makeBubble(deReg.valP);
         if (cntReg != {CNT_W{1'b1}}) cntNext = cntReg + 1'b1;
      end else if (fetchBus.valid_f && !illegal) begin
         deNext = '{valid: 1'b1, icode: icode, ifun: ifun, srcA: srcA, srcB: srcB,
                    dstE: dstE, valC: valC, valP: fetchBus.increPC_f};
      end else if (fetchBus.valid_f) begin
         deNext  = makeBubble(deReg.valP);
         errNext = 1'b1;
      end else begin
         deNext = makeBubble(deReg.valP);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deReg  <= makeBubble(8'h00);
         errReg <= 1'b0;
         cntReg <= '0;
      end else begin
         deReg  <= deNext;
         errReg <= errNext;
         cntReg <= cntNext;
      end
   end

   assign icode_d    = deReg.icode;
   assign ifun_d     = deReg.ifun;
   assign srcA_d     = deReg.srcA;
   assign srcB_d     = deReg.srcB;
   assign dstE_d     = deReg.dstE;
   assign valC_d     = deReg.valC;
   assign valP_d     = deReg.valP;
   assign valid_d    = deReg.valid;
   assign error_d    = errReg;
   assign bubble_cnt = cntReg;
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Decode stage of the 8-bit-address, 24-bit-instruction pipeline.
- Sits directly downstream of the fetch/PC stage and consumes its `instr_f`, `increPC_f` and `error` outputs.
- Splits the instruction into fields, selects source/destination registers and the constant, and detects load-use hazards against the execute stage.
- Registers everything into the D/E pipeline register that feeds execute.

Parameters:
- `REG_NONE`, 4'hF, register index meaning "no register".
- `CNT_W`, 8, width of the saturating hazard-bubble counter.

Ports:
- `clk`  input  1  pipeline clock; all state updates on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `instr_f`  input  24  fetched instruction: [23:20] icode, [19:16] ifun, [15:12] rA, [11:8] rB, [7:0]/[15:8] constant
- `increPC_f`  input  8  address of the next sequential instruction
- `valid_f`  input  1  `instr_f` is a real instruction this cycle
- `error_f`  input  1  fetch-stage error flag
- `stall_d`  input  1  execute cannot accept; hold the D/E register
- `flush_d`  input  1  mispredicted jump; squash the D/E register
- `dstE_e`  input  4  destination register of the instruction now in execute
- `isLoad_e`  input  1  instruction in execute is a load
- `stall_f`  output  1  combinational: fetch must hold `instr_f` next cycle
- `icode_d`, `ifun_d`  output  4 each  registered opcode fields
- `srcA_d`, `srcB_d`, `dstE_d`  output  4 each  registered register selectors
- `valC_d`  output  8  registered constant
- `valP_d`  output  8  registered `increPC_f`
- `valid_d`  output  1  D/E register holds a real instruction
- `error_d`  output  1  sticky decode/fetch error
- `bubble_cnt`  output  `CNT_W`  saturating count of hazard bubbles

Behaviour:
- Reset (async, `rst_n`=0):
  - `valid_d`=0, `icode_d`/`ifun_d`=0, `srcA_d`/`srcB_d`/`dstE_d`=`REG_NONE`.
  - `valC_d`/`valP_d`=0, `error_d`=0, `bubble_cnt`=0.
  - Deassertion mid-operation: the first edge after release behaves as a normal load.
- Field decode (combinational on `instr_f`):
  - icode 0: no register, no constant.
  - icode 1, ifun 0: register only.
  - icode 1, ifun 1 or 2: register and constant.
  - icode 1, ifun > 2: illegal.
  - icode 2: register and constant.
  - icode 3: register only.
  - icode 4: constant only; `valC` = [15:8].
  - icode 5: register and constant; `valC` = [7:0].
  - icode 6..15: illegal.
- Register selectors:
  - `srcA` = rA if the instruction has a register byte, else `REG_NONE`.
  - `srcB` = rB for icode 2 or 3, else `REG_NONE`.
  - `dstE` = rB for icode 1 or 3, else `REG_NONE`.
  - Constant: with a register byte, `valC` = [7:0]; constant-only, `valC` = [15:8]; no constant, `valC` = 0.
- Hazard detection:
  - `hazard` = `valid_f` & `isLoad_e` & `dstE_e` != `REG_NONE` & (`dstE_e` == `srcA` | `dstE_e` == `srcB`).
  - `stall_f` = `hazard` & !`flush_d`.
- Rising-edge update priority, evaluated in order (first match wins):
  1. `flush_d`: load a bubble (`valid_d`=0, `icode_d`=0, selectors=`REG_NONE`, `valC_d`=0).
  2. `stall_d`: hold all D/E outputs unchanged.
  3. `hazard`: load a bubble; `bubble_cnt` += 1, saturating at all-ones.
  4. `valid_f` and legal: load the decoded fields, `valP_d`=`increPC_f`, `valid_d`=1.
  5. `valid_f` and illegal: load a bubble and set `error_d`.
  6. `!valid_f`: load a bubble.
- Error handling:
  - `error_d` is set on any edge where `error_f`=1, or an illegal instruction is decoded (case 5).
  - It is cleared only by reset and is not blocked by `stall_d` or `flush_d`.
- Latency: one cycle from `instr_f` to the `_d` outputs. Throughput is one instruction per cycle when there is no stall or hazard.
- A hazard persists while fetch holds the same instruction. Each held cycle inserts one bubble and increments `bubble_cnt` once, until the execute stage's load has left.

Decomposition:
- Shared package/header holds:
  - icode constants (NOP, RRMOV/IRMOV group, MEM, OP, JMP, CALL);
  - `REG_NONE`;
  - `needReg`/`needCon` lookup, so the fetch stage and this block share one encoding table.
- One combinational sub-module, `instr_field_decode`: takes `instr_f`, produces icode/ifun/`srcA`/`srcB`/`dstE`/`valC`/`needReg`/`needCon`/`illegal`.
- Hazard logic, priority mux and counter stay in `decode_stage`.

Test Plan:
- Reset then `instr_f`=24'h312345, `valid_f`=1, `increPC_f`=8'h03 → next edge:
  - `icode_d`=3, `srcA_d`=2, `srcB_d`=3, `dstE_d`=3;
  - `valC_d`=0, `valP_d`=8'h03, `valid_d`=1.
- `instr_f`=24'h40A0xx (jump) → `valC_d`=8'hA0, `srcA_d`=`srcB_d`=`dstE_d`=4'hF. `instr_f`=24'h5312C4 → `valC_d`=8'hC4, `srcA_d`=1.
- `isLoad_e`=1, `dstE_e`=2, `instr_f`=24'h312345 held for 2 cycles → `stall_f`=1 both cycles, two bubbles, `bubble_cnt`=2. `isLoad_e`=0 → instruction loads.
- `stall_d` and `flush_d` asserted together while a hazard is present → flush wins: bubble, `stall_f`=0, `bubble_cnt` unchanged. `stall_d` alone → outputs held bit-exact.
- `instr_f`=24'h13xxxx, then icode 7 → bubble each time, `error_d`=1 and stays 1. `error_f` pulse also sets it. Only `rst_n` clears it.
- Force 255 hazard cycles plus 1 more → `bubble_cnt` saturates at 8'hFF. Assert `rst_n`=0 mid-stall, asynchronously → all outputs go to reset values before the next clock edge.
